multi_range_finder: RTL and testbench
=====================================

Name: multi_range_finder

Overview:
- Multi-channel, parametrised successor of the single-stream range finder.
- Tracks min/max/sample-count for CHANNELS independent interleaved sequences sharing one input bus; each sample is tagged with a channel index.
- Emits a registered result record (range, max, min, count, channel) with a one-cycle done pulse when a sequence finishes.
- Flags protocol errors with a code instead of a bare bit; supports signed or unsigned data via parameter.

Parameters:
- WIDTH, 16, data sample width in bits
- CHANNELS, 4, number of independent sequences (>=2)
- CNT_WIDTH, 8, per-channel sample counter width (saturating)
- SIGNED, 0, 1 = compare data as two's complement, 0 = unsigned

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- data_in  in  WIDTH  sample value
- chan  in  CH_W=$clog2(CHANNELS)  channel index qualifying go/finish/valid
- valid  in  1  data_in is a sample for channel chan
- go  in  1  start a sequence on chan
- finish  in  1  end the sequence on chan
- done  out  1  one-cycle pulse: result outputs are valid
- res_chan  out  CH_W  channel of the result
- range  out  WIDTH+1  max-min, zero-extended (unsigned) or exact difference (signed)
- high_q  out  WIDTH  final max
- low_q  out  WIDTH  final min
- count  out  CNT_WIDTH  samples in sequence, saturating
- active  out  CHANNELS  per-channel ACTIVE state bits
- error  out  1  one-cycle pulse on a protocol error
- error_code  out  2  last error code, held until the next error or reset

Behaviour:
- Reset, synchronous, dominates all inputs:
  - every channel goes to IDLE; max = 0, min = all-ones, count = 0
  - done = 0, error = 0, error_code = ERR_NONE
  - range, high_q, low_q, count, res_chan = 0; active = 0
  - in signed mode, max/min reset to most-negative/most-positive
- Per-channel FSM, IDLE/ACTIVE. Only channel chan is affected in a cycle; all other channels hold.
- Commands on chan, by case:
  - go=1, finish=1: command ignored (no state change), ERR_GO_FINISH.
  - go=1, channel IDLE: go to ACTIVE. If valid, max = min = data_in and count = 1; else max/min at reset values and count = 0.
  - go=1, channel ACTIVE: restart exactly as above (prior data discarded), ERR_RESTART.
  - valid=1 only, channel ACTIVE: update max/min by the SIGNED compare; count += 1, saturating at all-ones.
  - valid=1 only, channel IDLE: sample dropped; no error.
  - finish=1, channel ACTIVE: result includes data_in if valid (combinational bypass of the new max/min/count). Next cycle: done = 1, res_chan = chan, outputs = final values. Channel returns to IDLE with max/min/count at reset values.
  - finish=1, count would be 0: done still pulses, range = 0, high_q/low_q = reset values.
  - finish=1, channel IDLE: no done; ERR_FINISH_IDLE.
- Latency: done and results follow the finish edge by exactly one cycle. Result outputs hold until the next done; done itself is a single-cycle pulse.
- The error pulse aligns with done timing (one cycle after the offending command).
- Range arithmetic: WIDTH+1 bits, so a signed span (e.g. 0x7FFF - 0x8000 = 0x0FFFF) never overflows.
- Back-to-back finishes on different channels in consecutive cycles each produce one done.

Decomposition:
- Package multi_range_finder_pkg:
  - err_t enum: ERR_NONE=0, ERR_FINISH_IDLE=1, ERR_RESTART=2, ERR_GO_FINISH=3
  - ch_state_t enum: IDLE, ACTIVE
- One sub-module, range_channel: per-channel FSM, min/max/count registers and compare logic. Instantiated CHANNELS times via generate.
- Top level owns command decode, the result mux/register and error reporting.

Test Plan:
- Single channel, unsigned: go+valid 10 on ch0, valid 3, valid 25, finish -> next cycle done=1, res_chan=0, range=22, high_q=25, low_q=3, count=3.
- Interleaved channels: ch1 go 100; ch2 go 5; ch1 valid 40; ch2 valid 9; finish ch1, then finish ch2 next cycle -> done pulses:
  - ch1: range 60, count 2
  - ch2: range 4, count 2
- Signed mode (SIGNED=1, WIDTH=16): go 0x8000, valid 0x7FFF, finish -> range=0x0FFFF, high_q=0x7FFF, low_q=0x8000.
- Errors:
  - finish on IDLE ch3 -> error=1, error_code=1, no done
  - go twice on ch0 -> error_code=2, count restarts at 1
  - go+finish together -> error_code=3
- Saturation: CNT_WIDTH=4, 20 samples on ch0 -> count=15 at done.
- Reset mid-sequence: ch0 active with 3 samples, assert reset, then finish ch0 -> error_code=1, no done, active=0.

Source files
------------

// File: rtl/multi_range_finder_pkg.sv
// Shared types for the multi-channel range finder: error codes and per-channel FSM states.
package multi_range_finder_pkg;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_FINISH_IDLE = 2'd1,
        ERR_RESTART     = 2'd2,
        ERR_GO_FINISH   = 2'd3
    } err_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ch_state_t;

endpackage

// File: rtl/range_channel.sv
// One channel of the range finder: IDLE/ACTIVE FSM, running max/min, saturating sample count.
// The res_* outputs expose this cycle's updated values so a finish can fold in its own sample.
module range_channel
    import multi_range_finder_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 8,
    parameter bit          IS_SIGNED = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sel_i,
    input  logic                 go_i,
    input  logic                 finish_i,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic                 active_o,
    output logic [WIDTH-1:0]     res_max_o,
    output logic [WIDTH-1:0]     res_min_o,
    output logic [CNT_WIDTH-1:0] res_cnt_o
);

    // Reset values sit at the extremes of the number range so the first sample always wins.
    localparam logic [WIDTH-1:0] MaxRst = IS_SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MinRst = IS_SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

    ch_state_t             state_q, state_d;
    logic [WIDTH-1:0]      max_q, max_d;
    logic [WIDTH-1:0]      min_q, min_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  data_gt_max;
    logic                  data_lt_min;
    logic [WIDTH-1:0]      upd_max;
    logic [WIDTH-1:0]      upd_min;
    logic [CNT_WIDTH-1:0]  upd_cnt;

    always_comb begin
        if (IS_SIGNED) begin
            data_gt_max = $signed(data_i) > $signed(max_q);
            data_lt_min = $signed(data_i) < $signed(min_q);
        end else begin
            data_gt_max = data_i > max_q;
            data_lt_min = data_i < min_q;
        end
    end

    always_comb begin
        upd_max = max_q;
        upd_min = min_q;
        upd_cnt = cnt_q;
        if (valid_i) begin
            if (data_gt_max) upd_max = data_i;
            if (data_lt_min) upd_min = data_i;
            if (cnt_q != CntMax) upd_cnt = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        if (sel_i) begin
            if (go_i && !finish_i) begin
                // Start or restart: any prior data is discarded.
                state_d = ACTIVE;
                max_d   = valid_i ? data_i : MaxRst;
                min_d   = valid_i ? data_i : MinRst;
                cnt_d   = valid_i ? CNT_WIDTH'(1) : '0;
            end else if (!go_i && state_q == ACTIVE) begin
                if (finish_i) begin
                    state_d = IDLE;
                    max_d   = MaxRst;
                    min_d   = MinRst;
                    cnt_d   = '0;
                end else begin
                    max_d = upd_max;
                    min_d = upd_min;
                    cnt_d = upd_cnt;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            max_q   <= MaxRst;
            min_q   <= MinRst;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
        end
    end

    assign active_o  = (state_q == ACTIVE);
    assign res_max_o = upd_max;
    assign res_min_o = upd_min;
    assign res_cnt_o = upd_cnt;

endmodule

// File: rtl/multi_range_finder.sv
// Multi-channel range finder: command decode, per-channel trackers, registered result record
// with a done pulse, and coded protocol-error reporting.
module multi_range_finder
    import multi_range_finder_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned SIGNED    = 0,
    localparam int unsigned CH_W     = $clog2(CHANNELS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [CH_W-1:0]      chan,
    input  logic                 valid,
    input  logic                 go,
    input  logic                 finish,
    output logic                 done,
    output logic [CH_W-1:0]      res_chan,
    output logic [WIDTH:0]       range,
    output logic [WIDTH-1:0]     high_q,
    output logic [WIDTH-1:0]     low_q,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CHANNELS-1:0]  active,
    output logic                 error,
    output logic [1:0]           error_code
);

    localparam bit IsSigned = (SIGNED != 0);

    logic [WIDTH-1:0]     byp_max [CHANNELS];
    logic [WIDTH-1:0]     byp_min [CHANNELS];
    logic [CNT_WIDTH-1:0] byp_cnt [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        range_channel #(
            .WIDTH     (WIDTH),
            .CNT_WIDTH (CNT_WIDTH),
            .IS_SIGNED (IsSigned)
        ) u_ch (
            .clk_i     (clock),
            .rst_i     (reset),
            .sel_i     (chan == CH_W'(i)),
            .go_i      (go),
            .finish_i  (finish),
            .valid_i   (valid),
            .data_i    (data_in),
            .active_o  (active[i]),
            .res_max_o (byp_max[i]),
            .res_min_o (byp_min[i]),
            .res_cnt_o (byp_cnt[i])
        );
    end

    logic                 chan_ok;
    logic                 sel_active;
    logic                 fin_ok;
    logic [WIDTH-1:0]     sel_max;
    logic [WIDTH-1:0]     sel_min;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [WIDTH:0]       range_d;
    logic                 err_hit;
    err_t                 err_d;

    // Guards the index when CHANNELS is not a power of two.
    assign chan_ok    = ({1'b0, chan} < (CH_W+1)'(CHANNELS));
    assign sel_active = chan_ok && active[chan];
    assign fin_ok     = finish && !go && sel_active;
    assign sel_max    = byp_max[chan];
    assign sel_min    = byp_min[chan];
    assign sel_cnt    = byp_cnt[chan];

    always_comb begin
        range_d = '0;
        // One extra bit keeps a full signed span exact; an empty sequence reports zero.
        if (sel_cnt != '0) begin
            range_d = {IsSigned & sel_max[WIDTH-1], sel_max}
                    - {IsSigned & sel_min[WIDTH-1], sel_min};
        end
    end

    always_comb begin
        err_hit = 1'b0;
        err_d   = ERR_NONE;
        if (go && finish) begin
            err_hit = 1'b1;
            err_d   = ERR_GO_FINISH;
        end else if (go && sel_active) begin
            err_hit = 1'b1;
            err_d   = ERR_RESTART;
        end else if (finish && !sel_active) begin
            err_hit = 1'b1;
            err_d   = ERR_FINISH_IDLE;
        end
    end

    logic                 done_q;
    logic [CH_W-1:0]      res_chan_q;
    logic [WIDTH:0]       range_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 error_q;
    err_t                 error_code_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q       <= 1'b0;
            res_chan_q   <= '0;
            range_q      <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            count_q      <= '0;
            error_q      <= 1'b0;
            error_code_q <= ERR_NONE;
        end else begin
            done_q  <= fin_ok;
            error_q <= err_hit;
            if (fin_ok) begin
                res_chan_q <= chan;
                range_q    <= range_d;
                hi_q       <= sel_max;
                lo_q       <= sel_min;
                count_q    <= sel_cnt;
            end
            if (err_hit) error_code_q <= err_d;
        end
    end

    assign done       = done_q;
    assign res_chan   = res_chan_q;
    assign range      = range_q;
    assign high_q     = hi_q;
    assign low_q      = lo_q;
    assign count      = count_q;
    assign error      = error_q;
    assign error_code = error_code_q;

endmodule

// File: tb/tb_multi_range_finder.sv
// Directed bench for multi_range_finder: three instances (unsigned, signed, 4-bit count)
// share stimulus; a scoreboard of expected result records is checked on each done pulse.
module tb_multi_range_finder;

    logic        clock;
    logic        reset;
    logic [15:0] data_in;
    logic [1:0]  chan;
    logic        valid;
    logic        go;
    logic        finish;

    logic        d0_done, d1_done, d2_done;
    logic [1:0]  d0_rc, d1_rc, d2_rc;
    logic [16:0] d0_rng, d1_rng, d2_rng;
    logic [15:0] d0_hi, d1_hi, d2_hi;
    logic [15:0] d0_lo, d1_lo, d2_lo;
    logic [7:0]  d0_cnt, d1_cnt;
    logic [3:0]  d2_cnt;
    logic [3:0]  d0_act, d1_act, d2_act;
    logic        d0_err, d1_err, d2_err;
    logic [1:0]  d0_ec, d1_ec, d2_ec;

    multi_range_finder u_dut (
        .clock(clock), .reset(reset), .data_in(data_in), .chan(chan), .valid(valid),
        .go(go), .finish(finish), .done(d0_done), .res_chan(d0_rc), .range(d0_rng),
        .high_q(d0_hi), .low_q(d0_lo), .count(d0_cnt), .active(d0_act), .error(d0_err),
        .error_code(d0_ec)
    );

    multi_range_finder #(.SIGNED(1)) u_sgn (
        .clock(clock), .reset(reset), .data_in(data_in), .chan(chan), .valid(valid),
        .go(go), .finish(finish), .done(d1_done), .res_chan(d1_rc), .range(d1_rng),
        .high_q(d1_hi), .low_q(d1_lo), .count(d1_cnt), .active(d1_act), .error(d1_err),
        .error_code(d1_ec)
    );

    multi_range_finder #(.CNT_WIDTH(4)) u_sat (
        .clock(clock), .reset(reset), .data_in(data_in), .chan(chan), .valid(valid),
        .go(go), .finish(finish), .done(d2_done), .res_chan(d2_rc), .range(d2_rng),
        .high_q(d2_hi), .low_q(d2_lo), .count(d2_cnt), .active(d2_act), .error(d2_err),
        .error_code(d2_ec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    logic        m_done;
    logic [1:0]  m_rc;
    logic [16:0] m_rng;
    logic [15:0] m_hi, m_lo;
    logic [7:0]  m_cnt;
    logic [3:0]  m_act;
    logic        m_err;
    logic [1:0]  m_ec;

    always_comb begin
        m_done = d0_done; m_rc = d0_rc; m_rng = d0_rng; m_hi = d0_hi; m_lo = d0_lo;
        m_cnt = d0_cnt; m_act = d0_act; m_err = d0_err; m_ec = d0_ec;
        case (mode)
            1: begin
                m_done = d1_done; m_rc = d1_rc; m_rng = d1_rng; m_hi = d1_hi; m_lo = d1_lo;
                m_cnt = d1_cnt; m_act = d1_act; m_err = d1_err; m_ec = d1_ec;
            end
            2: begin
                m_done = d2_done; m_rc = d2_rc; m_rng = d2_rng; m_hi = d2_hi; m_lo = d2_lo;
                m_cnt = {4'b0, d2_cnt}; m_act = d2_act; m_err = d2_err; m_ec = d2_ec;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [1:0]  ch;
        logic [16:0] rng;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] c, input logic [16:0] r, input logic [15:0] h,
                            input logic [15:0] l, input logic [7:0] n);
        exp_t e;
        e.ch = c; e.rng = r; e.hi = h; e.lo = l; e.cnt = n;
        sb.push_back(e);
    endtask

    task automatic cmd(input logic [1:0] c, input logic g, input logic v, input logic f,
                       input logic [15:0] d);
        chan = c; go = g; valid = v; finish = f; data_in = d;
        @(posedge clock);
        #1;
        go = 1'b0; valid = 1'b0; finish = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cmd(2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (m_done === 1'b1) begin
            chk("done_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("res_chan", {30'b0, m_rc}, {30'b0, mon_e.ch});
                chk("range", {15'b0, m_rng}, {15'b0, mon_e.rng});
                chk("high_q", {16'b0, m_hi}, {16'b0, mon_e.hi});
                chk("low_q", {16'b0, m_lo}, {16'b0, mon_e.lo});
                chk("count", {24'b0, m_cnt}, {24'b0, mon_e.cnt});
            end
        end
    end

    initial begin
        reset = 1'b1; data_in = '0; chan = '0; valid = 1'b0; go = 1'b0; finish = 1'b0;
        do_reset();

        chk("rst_done", {31'b0, m_done}, 32'd0);
        chk("rst_error", {31'b0, m_err}, 32'd0);
        chk("rst_error_code", {30'b0, m_ec}, 32'd0);
        chk("rst_range", {15'b0, m_rng}, 32'd0);
        chk("rst_high", {16'b0, m_hi}, 32'd0);
        chk("rst_low", {16'b0, m_lo}, 32'd0);
        chk("rst_count", {24'b0, m_cnt}, 32'd0);
        chk("rst_active", {28'b0, m_act}, 32'd0);

        // Single channel, unsigned.
        cmd(2'd0, 1'b1, 1'b1, 1'b0, 16'd10);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 16'd3);
        chk("t1_active", {28'b0, m_act}, 32'h1);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 16'd25);
        push_exp(2'd0, 17'd22, 16'd25, 16'd3, 8'd3);
        cmd(2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        chk("t1_done", {31'b0, m_done}, 32'd1);
        chk("t1_active_after", {28'b0, m_act}, 32'h0);
        idle(1);
        chk("t1_done_pulse", {31'b0, m_done}, 32'd0);
        chk("t1_high_hold", {16'b0, m_hi}, 32'd25);

        // Interleaved channels with back-to-back finishes.
        cmd(2'd1, 1'b1, 1'b1, 1'b0, 16'd100);
        cmd(2'd2, 1'b1, 1'b1, 1'b0, 16'd5);
        cmd(2'd1, 1'b0, 1'b1, 1'b0, 16'd40);
        cmd(2'd2, 1'b0, 1'b1, 1'b0, 16'd9);
        chk("t2_active", {28'b0, m_act}, 32'h6);
        push_exp(2'd1, 17'd60, 16'd100, 16'd40, 8'd2);
        cmd(2'd1, 1'b0, 1'b0, 1'b1, 16'd0);
        push_exp(2'd2, 17'd4, 16'd9, 16'd5, 8'd2);
        cmd(2'd2, 1'b0, 1'b0, 1'b1, 16'd0);
        idle(1);

        // Finish carrying a sample folds it into the result.
        cmd(2'd3, 1'b1, 1'b1, 1'b0, 16'd7);
        push_exp(2'd3, 17'd13, 16'd20, 16'd7, 8'd2);
        cmd(2'd3, 1'b0, 1'b1, 1'b1, 16'd20);
        idle(1);

        // Empty sequence.
        cmd(2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        push_exp(2'd0, 17'd0, 16'h0000, 16'hFFFF, 8'd0);
        cmd(2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        idle(1);

        // Sample on an idle channel is dropped silently.
        cmd(2'd1, 1'b0, 1'b1, 1'b0, 16'd50);
        chk("drop_error", {31'b0, m_err}, 32'd0);
        chk("drop_active", {28'b0, m_act}, 32'h0);

        // Finish on idle channel.
        cmd(2'd3, 1'b0, 1'b0, 1'b1, 16'd0);
        chk("fin_idle_error", {31'b0, m_err}, 32'd1);
        chk("fin_idle_code", {30'b0, m_ec}, 32'd1);
        chk("fin_idle_no_done", {31'b0, m_done}, 32'd0);
        idle(1);
        chk("err_pulse", {31'b0, m_err}, 32'd0);
        chk("err_code_hold", {30'b0, m_ec}, 32'd1);

        // Restart discards prior data.
        cmd(2'd0, 1'b1, 1'b1, 1'b0, 16'd8);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 16'd9);
        cmd(2'd0, 1'b1, 1'b1, 1'b0, 16'd50);
        chk("restart_error", {31'b0, m_err}, 32'd1);
        chk("restart_code", {30'b0, m_ec}, 32'd2);
        push_exp(2'd0, 17'd0, 16'd50, 16'd50, 8'd1);
        cmd(2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        idle(1);

        // go and finish together are ignored.
        cmd(2'd0, 1'b1, 1'b1, 1'b1, 16'd4);
        chk("gofin_code", {30'b0, m_ec}, 32'd3);
        chk("gofin_active", {28'b0, m_act}, 32'h0);
        chk("gofin_no_done", {31'b0, m_done}, 32'd0);

        // Reset in the middle of a sequence.
        cmd(2'd0, 1'b1, 1'b1, 1'b0, 16'd1);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 16'd2);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 16'd3);
        chk("mid_active", {28'b0, m_act}, 32'h1);
        do_reset();
        chk("mid_rst_active", {28'b0, m_act}, 32'h0);
        chk("mid_rst_code", {30'b0, m_ec}, 32'd0);
        cmd(2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        chk("mid_fin_code", {30'b0, m_ec}, 32'd1);
        chk("mid_fin_no_done", {31'b0, m_done}, 32'd0);
        idle(2);

        // Signed instance.
        mode = 1;
        do_reset();
        chk("sgn_rst_active", {28'b0, m_act}, 32'h0);
        cmd(2'd0, 1'b1, 1'b1, 1'b0, 16'h8000);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 16'h7FFF);
        push_exp(2'd0, 17'h0FFFF, 16'h7FFF, 16'h8000, 8'd2);
        cmd(2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        cmd(2'd1, 1'b1, 1'b1, 1'b0, 16'hFFFB);
        cmd(2'd1, 1'b0, 1'b1, 1'b0, 16'd3);
        cmd(2'd1, 1'b0, 1'b1, 1'b0, 16'hFFF6);
        push_exp(2'd1, 17'd13, 16'd3, 16'hFFF6, 8'd3);
        cmd(2'd1, 1'b0, 1'b0, 1'b1, 16'd0);
        cmd(2'd2, 1'b1, 1'b0, 1'b0, 16'd0);
        push_exp(2'd2, 17'd0, 16'h8000, 16'h7FFF, 8'd0);
        cmd(2'd2, 1'b0, 1'b0, 1'b1, 16'd0);
        idle(2);

        // Saturating 4-bit counter.
        mode = 2;
        do_reset();
        cmd(2'd0, 1'b1, 1'b1, 1'b0, 16'd0);
        for (int i = 1; i < 20; i++) cmd(2'd0, 1'b0, 1'b1, 1'b0, 16'(i));
        push_exp(2'd0, 17'd19, 16'd19, 16'd0, 8'd15);
        cmd(2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        idle(3);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
